// File: rtl/ir_regfile_alu_seq_pkg.sv
// Shared opcodes, funct codes, ALU operation and sequencer state types for the IR/regfile/ALU slice.
package ir_alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SLT, LUI, PASS} alu_op_t;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  // r0 is hardwired to zero and indices past the implemented file do not exist
  function automatic logic reg_ok(input logic [4:0] idx, input int nregs);
    return (idx != 5'd0) && (int'(idx) < nregs);
  endfunction

endpackage

// File: rtl/ir_regfile_alu_seq_if.sv
// Instruction issue handshake, registered result flags and debug register read port.
interface ir_regfile_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr_in;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             done;
  logic [4:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output instr_valid, instr_in, pc_in, dbg_addr,
    input  instr_ready, result, zero, overflow, illegal, done, dbg_data
  );

  modport slave (
    input  instr_valid, instr_in, pc_in, dbg_addr,
    output instr_ready, result, zero, overflow, illegal, done, dbg_data
  );
endinterface

// File: rtl/ir_regfile_alu_seq_alu.sv
// Combinational ALU: y/zero/signed-overflow for one alu_op_t, no state.
// Overflow is reported only for ADD and SUB; every other op clears it.
module irx_alu
  import ir_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ovf
);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      ADD: begin
        y   = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        y   = a - b;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      AND:  y = a & b;
      OR:   y = a | b;
      XOR:  y = a ^ b;
      SLT:  y = WIDTH'($signed(a) < $signed(b));
      LUI:  y = b << 16;
      PASS: y = b;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/ir_regfile_alu_seq.sv
// Multicycle IR/regfile/ALU slice: IDLE -> DECODE -> EXEC -> WB, one instruction per handshake.
// Accept at edge N, done high for the cycle ending at edge N+3, ready again for an accept at N+4.
module ir_regfile_alu_seq
  import ir_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  ir_regfile_alu_seq_if.slave bus
);

  localparam int REG_AW = $clog2(NREGS);

  state_t           state, state_nxt;
  logic [31:0]      ir;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] a_q, b_q;
  alu_op_t          op_q;
  logic [4:0]       dest_q;
  logic             legal_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, illegal_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [5:0]  op_f, funct_f;
  logic [4:0]  rs_f, rt_f, rd_f;
  logic [15:0] imm_f;

  assign op_f    = ir[31:26];
  assign rs_f    = ir[25:21];
  assign rt_f    = ir[20:16];
  assign rd_f    = ir[15:11];
  assign imm_f   = ir[15:0];
  assign funct_f = ir[5:0];

  function automatic logic [WIDTH-1:0] rf_rd(input logic [4:0] idx);
    return reg_ok(idx, NREGS) ? regs[idx[REG_AW-1:0]] : '0;
  endfunction

  logic [WIDTH-1:0] rs_val, rt_val, dbg_val;

  always_comb begin
    rs_val  = rf_rd(rs_f);
    rt_val  = rf_rd(rt_f);
    dbg_val = rf_rd(bus.dbg_addr);
  end

  // Undecodable instructions fall through as PASS of zero so result=0/zero=1 come for free
  alu_op_t          dec_op;
  logic [WIDTH-1:0] dec_b;
  logic [4:0]       dec_dest;
  logic             dec_legal;

  always_comb begin
    dec_op    = PASS;
    dec_b     = '0;
    dec_dest  = rd_f;
    dec_legal = 1'b0;
    case (op_f)
      OP_RTYPE: begin
        dec_b     = rt_val;
        dec_legal = 1'b1;
        case (funct_f)
          FN_ADD: dec_op = ADD;
          FN_SUB: dec_op = SUB;
          FN_AND: dec_op = AND;
          FN_OR:  dec_op = OR;
          FN_XOR: dec_op = XOR;
          FN_SLT: dec_op = SLT;
          default: begin
            dec_legal = 1'b0;
            dec_b     = '0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_op = ADD; dec_b = WIDTH'($signed(imm_f)); dec_dest = rt_f; dec_legal = 1'b1;
      end
      OP_SLTI: begin
        dec_op = SLT; dec_b = WIDTH'($signed(imm_f)); dec_dest = rt_f; dec_legal = 1'b1;
      end
      OP_ORI: begin
        dec_op = OR; dec_b = WIDTH'(imm_f); dec_dest = rt_f; dec_legal = 1'b1;
      end
      OP_LUI: begin
        dec_op = LUI; dec_b = WIDTH'(imm_f); dec_dest = rt_f; dec_legal = 1'b1;
      end
      OP_JAL: begin
        dec_op = PASS; dec_b = pc + WIDTH'(32'd4); dec_dest = LINK_REG; dec_legal = 1'b1;
      end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] alu_y;
  logic             alu_zero, alu_ovf;

  irx_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  logic ready_c, done_c;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.instr_valid) state_nxt = DECODE;
      end
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = WB;
      WB: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      pc        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= PASS;
      dest_q    <= '0;
      legal_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) begin
          ir <= bus.instr_in;
          pc <= bus.pc_in;
        end
        DECODE: begin
          a_q     <= rs_val;
          b_q     <= dec_b;
          op_q    <= dec_op;
          dest_q  <= dec_dest;
          legal_q <= dec_legal;
        end
        EXEC: begin
          result_q  <= alu_y;
          zero_q    <= alu_zero;
          ovf_q     <= alu_ovf;
          illegal_q <= !legal_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WB && legal_q && reg_ok(dest_q, NREGS)) begin
      regs[dest_q[REG_AW-1:0]] <= result_q;
    end
  end

  assign bus.instr_ready = ready_c;
  assign bus.done        = done_c;
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.illegal     = illegal_q;
  assign bus.dbg_data    = dbg_val;

endmodule

// File: tb/tb_ir_regfile_alu_seq.sv
// Bench for ir_regfile_alu_seq: a 32-bit/32-reg and a 16-bit/8-reg instance, directed plus random
// instructions, expectations from an arithmetic reference model queued per instance and popped on done.
module tb_ir_regfile_alu_seq;

  typedef struct {
    longint res;
    bit     zero;
    bit     ovf;
    bit     ill;
    bit     wr;
    int     dest;
    int     hs;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n0, rst_n1;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  exp_t   sb_q [2][$];
  longint mreg [2][32];
  exp_t   mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ir_regfile_alu_seq_if #(.WIDTH(32)) bus0 ();
  ir_regfile_alu_seq_if #(.WIDTH(16)) bus1 ();

  ir_regfile_alu_seq #(.WIDTH(32), .NREGS(32)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(bus0.slave));
  ir_regfile_alu_seq #(.WIDTH(16), .NREGS(8))  dut1 (.clk(clk), .rst_n(rst_n1), .bus(bus1.slave));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int wid(input int id); return (id == 0) ? 32 : 16; endfunction
  function automatic int nr(input int id);  return (id == 0) ? 32 : 8;  endfunction

  function automatic longint o_res(input int id);  return (id == 0) ? longint'(bus0.result)      : longint'(bus1.result);      endfunction
  function automatic longint o_dbg(input int id);  return (id == 0) ? longint'(bus0.dbg_data)    : longint'(bus1.dbg_data);    endfunction
  function automatic bit     o_rdy(input int id);  return (id == 0) ? bus0.instr_ready           : bus1.instr_ready;           endfunction
  function automatic bit     o_done(input int id); return (id == 0) ? bus0.done                  : bus1.done;                  endfunction
  function automatic bit     o_zero(input int id); return (id == 0) ? bus0.zero                  : bus1.zero;                  endfunction
  function automatic bit     o_ovf(input int id);  return (id == 0) ? bus0.overflow              : bus1.overflow;              endfunction
  function automatic bit     o_ill(input int id);  return (id == 0) ? bus0.illegal               : bus1.illegal;               endfunction

  function automatic logic [31:0] rt_ins(input int fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] it_ins(input int op, input int rt, input int rs, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic longint mrd(input int id, input int idx);
    return (idx == 0 || idx >= nr(id)) ? 64'd0 : mreg[id][idx];
  endfunction

  function automatic longint as_signed(input longint v, input int w);
    return (v >= (longint'(1) << (w - 1))) ? v - (longint'(1) << w) : v;
  endfunction

  // Reference semantics in plain integer arithmetic: overflow = true sum outside the signed range
  function automatic exp_t model(input int id, input logic [31:0] ins, input longint pc);
    exp_t   e;
    int     w    = wid(id);
    longint m    = (longint'(1) << w) - 1;
    longint hi   = (longint'(1) << (w - 1)) - 1;
    longint lo   = -(longint'(1) << (w - 1));
    int     op   = int'(ins[31:26]);
    int     rs   = int'(ins[25:21]);
    int     rt   = int'(ins[20:16]);
    int     rd   = int'(ins[15:11]);
    int     fn   = int'(ins[5:0]);
    longint imm  = longint'(ins[15:0]);
    longint simm = (imm >= 32768) ? imm - 65536 : imm;
    longint ra   = mrd(id, rs);
    longint rb   = mrd(id, rt);
    longint sa   = as_signed(ra, w);
    longint sb   = as_signed(rb, w);
    longint s;
    e.res = 0; e.ovf = 0; e.ill = 0; e.dest = rd; e.hs = 0;
    case (op)
      0: case (fn)
        'h20: begin s = sa + sb; e.ovf = (s > hi) || (s < lo); e.res = s & m; end
        'h22: begin s = sa - sb; e.ovf = (s > hi) || (s < lo); e.res = s & m; end
        'h24: e.res = ra & rb;
        'h25: e.res = ra | rb;
        'h26: e.res = ra ^ rb;
        'h2A: e.res = (sa < sb) ? 1 : 0;
        default: e.ill = 1;
      endcase
      'h08: begin s = sa + simm; e.ovf = (s > hi) || (s < lo); e.res = s & m; e.dest = rt; end
      'h0A: begin e.res = (sa < simm) ? 1 : 0; e.dest = rt; end
      'h0D: begin e.res = ra | imm; e.dest = rt; end
      'h0F: begin e.res = (imm << 16) & m; e.dest = rt; end
      'h03: begin e.res = (pc + 4) & m; e.dest = 31; end
      default: e.ill = 1;
    endcase
    if (e.ill) e.res = 0;
    e.zero = (e.res == 0);
    e.wr   = !e.ill && e.dest != 0 && e.dest < nr(id);
    return e;
  endfunction

  task automatic drive(input int id, input bit v, input logic [31:0] ins, input longint pc);
    if (id == 0) begin
      bus0.instr_valid = v; bus0.instr_in = ins; bus0.pc_in = pc[31:0];
    end else begin
      bus1.instr_valid = v; bus1.instr_in = ins; bus1.pc_in = pc[15:0];
    end
  endtask

  task automatic set_dbg(input int id, input int a);
    if (id == 0) bus0.dbg_addr = 5'(a);
    else         bus1.dbg_addr = 5'(a);
  endtask

  task automatic issue(input int id, input logic [31:0] ins, input longint pc, input bit expect_done,
                       output int hs);
    int   b = 0;
    exp_t e;
    @(negedge clk);
    while (!o_rdy(id) && b < 50) begin @(negedge clk); b++; end
    chk($sformatf("d%0d_ready_before_issue", id), longint'(b < 50), 1);
    drive(id, 1'b1, ins, pc);
    @(posedge clk);
    #1;
    hs = cyc;
    drive(id, 1'b0, ins, pc);
    if (expect_done) begin
      e    = model(id, ins, pc);
      e.hs = hs;
      sb_q[id].push_back(e);
      if (e.wr) mreg[id][e.dest] = e.res;
    end
  endtask

  task automatic wait_idle(input int id, output int t);
    int b = 0;
    @(negedge clk);
    while (!o_rdy(id) && b < 50) begin @(negedge clk); b++; end
    chk($sformatf("d%0d_return_to_idle", id), longint'(b < 50), 1);
    t = cyc;
  endtask

  task automatic run(input int id, input logic [31:0] ins, input longint pc = 0);
    int hs, t;
    issue(id, ins, pc, 1'b1, hs);
    wait_idle(id, t);
  endtask

  task automatic reg_check(input int id, input int idx, input string nm);
    set_dbg(id, idx);
    #1;
    chk($sformatf("d%0d_%s_r%0d", id, nm, idx), o_dbg(id), mrd(id, idx));
  endtask

  task automatic const_check(input int id, input int idx, input string nm, input longint val);
    set_dbg(id, idx);
    #1;
    chk($sformatf("d%0d_%s", id, nm), o_dbg(id), val);
  endtask

  task automatic sweep(input int id, input string nm);
    for (int i = 0; i < 32; i++) reg_check(id, i, nm);
  endtask

  task automatic scen_basic(input int id);
    int hs, t;
    issue(id, it_ins('h08, 1, 0, 'h7FFF), 0, 1'b1, hs);
    wait_idle(id, t);
    chk($sformatf("d%0d_accept_to_ready_cycles", id), longint'(t - hs), 3);
    const_check(id, 1, "addi_r1", 'h7FFF);
    if (id == 1) begin
      run(1, it_ins('h08, 9, 0, 'h1234));
      const_check(1, 9, "r9_write_dropped", 0);
      run(1, it_ins('h08, 7, 1, 1));
      const_check(1, 7, "r7_top_reg", 'h8000);
    end
  endtask

  task automatic scen_directed0();
    run(0, it_ins('h08, 1, 0, 5));
    run(0, it_ins('h08, 2, 0, 7));
    run(0, rt_ins('h22, 3, 1, 2));
    const_check(0, 3, "sub_r3", 'hFFFFFFFE);
    run(0, rt_ins('h2A, 4, 1, 2));
    const_check(0, 4, "slt_r4", 1);
    run(0, it_ins('h0F, 1, 0, 'h7FFF));
    run(0, it_ins('h0D, 1, 1, 'hFFFF));
    run(0, rt_ins('h20, 5, 1, 1));
    const_check(0, 5, "add_ovf_r5", 'hFFFFFFFE);
    run(0, it_ins('h08, 0, 0, 5));
    const_check(0, 0, "r0_stays_zero", 0);
    run(0, {6'h03, 26'h0100000}, 64'h00400000);
    const_check(0, 31, "jal_link", 'h00400004);
    run(0, it_ins('h0F, 6, 0, 'hABCD));
    const_check(0, 6, "lui_r6", 'hABCD0000);
    run(0, {6'h3F, 26'h3FFFFFF});
    sweep(0, "after_illegal");
  endtask

  task automatic rand_run(input int id, input int n, input int maxr);
    int bad_ops [4] = '{'h3F, 'h02, 'h23, 'h2B};
    int fns [6]     = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h2A};
    for (int i = 0; i < n; i++) begin
      int          k, rs, rt, rd, imm;
      logic [31:0] ins;
      longint      pc;
      k   = $urandom_range(0, 12);
      rs  = $urandom_range(0, maxr);
      rt  = $urandom_range(0, maxr);
      rd  = $urandom_range(0, maxr);
      imm = $urandom_range(0, 65535);
      pc  = longint'($urandom);
      case (k)
        0, 1, 2, 3, 4, 5: ins = rt_ins(fns[k], rd, rs, rt);
        6:  ins = it_ins('h08, rt, rs, imm);
        7:  ins = it_ins('h0A, rt, rs, imm);
        8:  ins = it_ins('h0D, rt, rs, imm);
        9:  ins = it_ins('h0F, rt, rs, imm);
        10: ins = {6'h03, 26'($urandom)};
        11: ins = {6'(bad_ops[$urandom_range(0, 3)]), 26'($urandom)};
        default: ins = rt_ins('h21, rd, rs, rt);
      endcase
      run(id, ins, pc);
      reg_check(id, $urandom_range(0, 31), "rand");
      if (i % 25 == 24) sweep(id, "rand_sweep");
    end
  endtask

  task automatic scen_abort();
    int hs;
    issue(0, it_ins('h08, 7, 0, 9), 0, 1'b0, hs);
    @(posedge clk);
    #2;
    rst_n0 = 1'b0;
    for (int i = 0; i < 32; i++) mreg[0][i] = 0;
    #3;
    @(negedge clk);
    rst_n0 = 1'b1;
    repeat (6) @(negedge clk);
    chk("d0_ready_after_abort", longint'(o_rdy(0)), 1);
    chk("d0_result_after_abort", o_res(0), 0);
    const_check(0, 7, "r7_not_written", 0);
    sweep(0, "after_abort");
  endtask

  // Done is sampled at the falling edge after accept edge + 2, i.e. it is high at accept edge + 3
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (o_done(id)) begin
        chk($sformatf("d%0d_done_expected", id), longint'(sb_q[id].size() > 0), 1);
        if (sb_q[id].size() > 0) begin
          mon_e = sb_q[id].pop_front();
          chk($sformatf("d%0d_result", id),       o_res(id), mon_e.res);
          chk($sformatf("d%0d_zero", id),         longint'(o_zero(id)), longint'(mon_e.zero));
          chk($sformatf("d%0d_overflow", id),     longint'(o_ovf(id)),  longint'(mon_e.ovf));
          chk($sformatf("d%0d_illegal", id),      longint'(o_ill(id)),  longint'(mon_e.ill));
          chk($sformatf("d%0d_done_latency", id), longint'(cyc - mon_e.hs), 2);
          chk($sformatf("d%0d_busy_at_done", id), longint'(o_rdy(id)), 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 1'b0, 32'd0, 0);
    drive(1, 1'b0, 32'd0, 0);
    set_dbg(0, 0);
    set_dbg(1, 0);
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    #1;
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("d%0d_reset_ready", id),    longint'(o_rdy(id)), 1);
      chk($sformatf("d%0d_reset_result", id),   o_res(id), 0);
      chk($sformatf("d%0d_reset_zero", id),     longint'(o_zero(id)), 0);
      chk($sformatf("d%0d_reset_overflow", id), longint'(o_ovf(id)), 0);
      chk($sformatf("d%0d_reset_illegal", id),  longint'(o_ill(id)), 0);
      chk($sformatf("d%0d_reset_done", id),     longint'(o_done(id)), 0);
    end
    scen_basic(0);
    scen_basic(1);
    scen_directed0();
    rand_run(0, 150, 7);
    rand_run(1, 100, 11);
    sweep(1, "final");
    scen_abort();
    repeat (4) @(negedge clk);
    chk("d0_queue_drained", longint'(sb_q[0].size()), 0);
    chk("d1_queue_drained", longint'(sb_q[1].size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
